// File: rtl/stack_op_sequencer_pkg.sv
// Shared types and constants for the stack instruction sequencer.
// Op encoding, M-cycle lengths and incrementer direction codes.
package stack_op_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_POP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_RET   = 3'd2,
        OP_RETI  = 3'd3,
        OP_RETCC = 3'd4,
        OP_RST   = 3'd5
    } stack_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } seq_state_e;

    localparam int DEF_STEPS    = 4;
    localparam int DEF_PAIRS    = 4;
    localparam int DEF_REG16_W  = 6;
    localparam int DEF_SP_INDEX = 4;
    localparam int DEF_PC_INDEX = 5;
    localparam int MCYC_W       = 3;

    localparam logic [1:0] INC_NONE = 2'b00;
    localparam logic [1:0] INC_UP   = 2'b01;
    localparam logic [1:0] INC_DN   = 2'b10;

    // RET cc runs a single internal M-cycle when the condition fails.
    function automatic logic [MCYC_W-1:0] op_mcycles(
        stack_op_e op,
        logic      cond
    );
        logic [MCYC_W-1:0] n;
        n = MCYC_W'(1);
        case (op)
            OP_POP:   n = MCYC_W'(2);
            OP_PUSH:  n = MCYC_W'(3);
            OP_RET:   n = MCYC_W'(3);
            OP_RETI:  n = MCYC_W'(3);
            OP_RETCC: n = cond ? MCYC_W'(4) : MCYC_W'(1);
            OP_RST:   n = MCYC_W'(3);
            default:  n = MCYC_W'(1);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/stack_op_sequencer_step_counter.sv
// T-step / M-cycle counter with a memory-wait hold on the last step.
// mcycle_end flags the edge where the current M-cycle actually retires.
module stack_step_counter #(
    parameter int STEPS = 4,
    parameter int MW    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     run,
    input  logic                     hold,
    output logic [$clog2(STEPS)-1:0] step,
    output logic [MW-1:0]            mcycle,
    output logic                     mcycle_end
);

    localparam int SW = $clog2(STEPS);

    logic step_last;

    assign step_last  = (step == SW'(STEPS - 1));
    assign mcycle_end = run & step_last & ~hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step   <= '0;
            mcycle <= '0;
        end else if (clear) begin
            step   <= '0;
            mcycle <= '0;
        end else if (run && !(step_last && hold)) begin
            step <= step + 1'b1;
            if (step_last) begin
                mcycle <= mcycle + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Microcode sequencer for SP-relative ops: POP, PUSH, RET, RETI, RET cc, RST.
// Outputs are a combinational decode of the latched op and step counters.
module stack_op_sequencer
    import stack_op_sequencer_pkg::*;
#(
    parameter int STEPS_PER_MCYCLE = DEF_STEPS,
    parameter int PAIR_COUNT       = DEF_PAIRS,
    parameter int REG16_W          = DEF_REG16_W,
    parameter int SP_INDEX         = DEF_SP_INDEX,
    parameter int PC_INDEX         = DEF_PC_INDEX
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset_n,
    input  logic                          i_Start,
    input  logic [2:0]                    i_Op,
    input  logic [PAIR_COUNT-1:0]         i_P,
    input  logic [2:0]                    i_Rst_Vec,
    input  logic                          i_Cond,
    input  logic                          i_Wait,
    output logic                          o_Busy,
    output logic                          o_Done,
    output logic                          o_IR_Fetch,
    output logic [2*(PAIR_COUNT-1)-1:0]   o_Write8,
    output logic [2*(PAIR_COUNT-1)-1:0]   o_Read8,
    output logic [1:0]                    o_WriteALU8,
    output logic [1:0]                    o_ReadALU8,
    output logic [1:0]                    o_WritePC8,
    output logic [1:0]                    o_ReadPC8,
    output logic [REG16_W-1:0]            o_Read16,
    output logic [REG16_W-1:0]            o_Write16,
    output logic                          o_Bus_In,
    output logic                          o_Bus_Out,
    output logic                          o_Address_Out,
    output logic [1:0]                    o_Increment16,
    output logic                          o_Load_Vector,
    output logic [15:0]                   o_Vector,
    output logic                          o_IME_Set
);

    localparam int SW = $clog2(STEPS_PER_MCYCLE);

    seq_state_e              state;
    stack_op_e               op_q;
    logic [PAIR_COUNT-1:0]   p_q;
    logic [2:0]              vec_q;
    logic                    cond_q;

    logic [SW-1:0]           step;
    logic [MCYC_W-1:0]       mcycle;
    logic                    mcycle_end;

    logic                    run;
    logic                    start_ok;
    logic                    done;
    logic                    first_step;
    logic                    cond_eff;
    logic [MCYC_W-1:0]       total;
    logic                    is_last_m;
    logic [MCYC_W-1:0]       seq_m;

    logic                    is_pop;
    logic                    is_push;
    logic                    is_ret;
    logic                    pc_data;
    logic                    af;
    logic                    t0;
    logic                    t1;

    logic [1:0]              wr2;
    logic [1:0]              rd2;
    logic                    mem;
    logic                    bus_in;
    logic                    bus_out;
    logic                    sp_wr;
    logic                    pc_wr;
    logic                    ld_vec;
    logic [1:0]              inc;

    assign run        = (state == ST_RUN);
    assign start_ok   = (state == ST_IDLE) & i_Start;
    assign first_step = (mcycle == '0) & (step == '0);

    // The RET cc condition is live on its sampling step, latched afterwards.
    assign cond_eff  = first_step ? i_Cond : cond_q;
    assign total     = op_mcycles(op_q, cond_eff);
    assign is_last_m = (mcycle == total - MCYC_W'(1));
    assign done      = run & is_last_m & mcycle_end;

    stack_step_counter #(
        .STEPS (STEPS_PER_MCYCLE),
        .MW    (MCYC_W)
    ) u_cnt (
        .clk        (i_Clk),
        .rst_n      (i_Reset_n),
        .clear      (start_ok | done),
        .run        (run),
        .hold       (i_Wait),
        .step       (step),
        .mcycle     (mcycle),
        .mcycle_end (mcycle_end)
    );

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state  <= ST_IDLE;
            op_q   <= OP_POP;
            p_q    <= '0;
            vec_q  <= '0;
            cond_q <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_Start) begin
                        state  <= ST_RUN;
                        op_q   <= stack_op_e'(i_Op);
                        p_q    <= i_P;
                        cond_q <= 1'b0;
                        if (i_Op == OP_RST) begin
                            vec_q <= i_Rst_Vec;
                        end
                    end
                end
                ST_RUN: begin
                    if (op_q == OP_RETCC && first_step) begin
                        cond_q <= i_Cond;
                    end
                    if (done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign is_pop  = (op_q == OP_POP);
    assign is_push = (op_q == OP_PUSH) | (op_q == OP_RST);
    assign is_ret  = (op_q == OP_RET) | (op_q == OP_RETI) |
                     ((op_q == OP_RETCC) & (mcycle != '0));
    assign pc_data = is_ret | (op_q == OP_RST);
    assign af      = p_q[PAIR_COUNT-1];
    assign t0      = (step == SW'(0));
    assign t1      = (step == SW'(1));
    assign seq_m   = (op_q == OP_RETCC) ? mcycle - MCYC_W'(1) : mcycle;

    always_comb begin
        wr2     = 2'b00;
        rd2     = 2'b00;
        mem     = 1'b0;
        bus_in  = 1'b0;
        bus_out = 1'b0;
        sp_wr   = 1'b0;
        pc_wr   = 1'b0;
        ld_vec  = 1'b0;
        inc     = INC_NONE;
        if (run) begin
            unique case (1'b1)
                is_pop: begin
                    if (t0) begin
                        mem    = 1'b1;
                        bus_in = 1'b1;
                        wr2    = (mcycle == '0) ? 2'b01 : 2'b10;
                    end
                    if (t1) begin
                        sp_wr = 1'b1;
                        inc   = INC_UP;
                    end
                end
                is_push: begin
                    if (t0 && mcycle != '0) begin
                        mem     = 1'b1;
                        bus_out = 1'b1;
                        rd2     = (mcycle == MCYC_W'(1)) ? 2'b10 : 2'b01;
                    end
                    if (t1 && mcycle != MCYC_W'(2)) begin
                        sp_wr = 1'b1;
                        inc   = INC_DN;
                    end
                    if (t1 && mcycle == MCYC_W'(2) && op_q == OP_RST) begin
                        ld_vec = 1'b1;
                    end
                end
                is_ret: begin
                    if (seq_m == MCYC_W'(2)) begin
                        pc_wr = t0;
                    end else begin
                        if (t0) begin
                            mem    = 1'b1;
                            bus_in = 1'b1;
                            wr2    = (seq_m == '0) ? 2'b01 : 2'b10;
                        end
                        if (t1) begin
                            sp_wr = 1'b1;
                            inc   = INC_UP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_Write8    = '0;
        o_Read8     = '0;
        o_WriteALU8 = 2'b00;
        o_ReadALU8  = 2'b00;
        o_WritePC8  = 2'b00;
        o_ReadPC8   = 2'b00;
        o_Read16    = '0;
        o_Write16   = '0;
        if (pc_data) begin
            o_WritePC8 = wr2;
            o_ReadPC8  = rd2;
        end else if (af) begin
            o_WriteALU8 = wr2;
            o_ReadALU8  = rd2;
        end else begin
            for (int i = 0; i < PAIR_COUNT - 1; i++) begin
                if (p_q[i]) begin
                    o_Write8[2*i +: 2] = wr2;
                    o_Read8[2*i +: 2]  = rd2;
                end
            end
        end
        o_Read16[SP_INDEX]  = mem;
        o_Write16[SP_INDEX] = sp_wr;
        o_Write16[PC_INDEX] = pc_wr;
    end

    assign o_Busy        = run;
    assign o_Done        = done;
    assign o_IR_Fetch    = run & is_last_m;
    assign o_Bus_In      = bus_in;
    assign o_Bus_Out     = bus_out;
    assign o_Address_Out = mem;
    assign o_Increment16 = inc;
    assign o_Load_Vector = ld_vec;
    assign o_Vector      = {10'b0, vec_q, 3'b000};
    assign o_IME_Set     = done & (op_q == OP_RETI);

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Clocked microcode sequencer for all SP-relative stack instructions: POP rr, PUSH rr, RET, RETI, RET cc, RST n.
- Owns its own T-step and M-cycle counters instead of relying on external cycle strobes.
- Drives the register-file, bus and SP incrementer control lines, in the same bit layout as the other microcode blocks.
- Started by the decoder in the control unit; returns control via o_Done/o_IR_Fetch.

Parameters:
- STEPS_PER_MCYCLE, 4, T-steps per M-cycle (power of two, >=2)
- PAIR_COUNT, 4, one-hot register-pair select width; the top pair (AF) routes to the ALU flag/acc path
- REG16_W, 6, width of 16-bit register read/write/select vectors
- SP_INDEX, 4, bit of SP in 16-bit vectors
- PC_INDEX, 5, bit of PC in 16-bit vectors

Ports:
- i_Clk  in  1  system clock
- i_Reset_n  in  1  reset; asynchronous, active-low
- i_Start  in  1  one-cycle start pulse from the decoder
- i_Op  in  3  op code (package enum)
- i_P  in  PAIR_COUNT  one-hot pair select (PUSH/POP)
- i_Rst_Vec  in  3  RST target index
- i_Cond  in  1  condition result for RET cc
- i_Wait  in  1  memory wait; stalls the M-cycle boundary
- o_Busy  out  1  op in progress
- o_Done  out  1  one-cycle completion pulse
- o_IR_Fetch  out  1  final M-cycle indicator; next M-cycle is the opcode fetch
- o_Write8  out  2*(PAIR_COUNT-1)  {hi,lo} write enables per non-AF pair
- o_Read8  out  2*(PAIR_COUNT-1)  {hi,lo} read enables per non-AF pair
- o_WriteALU8  out  2  AF {A,F} write enables
- o_ReadALU8  out  2  AF {A,F} read enables
- o_WritePC8  out  2  PC {hi,lo} byte write enables
- o_ReadPC8  out  2  PC {hi,lo} byte read enables
- o_Read16  out  REG16_W  16-bit source selected onto the address bus
- o_Write16  out  REG16_W  16-bit destination write-back
- o_Bus_In  out  1  data bus to internal
- o_Bus_Out  out  1  internal to data bus (memory write)
- o_Address_Out  out  1  drive address bus
- o_Increment16  out  2  {dec, inc} for the 16-bit incrementer
- o_Load_Vector  out  1  load PC from o_Vector
- o_Vector  out  16  {10'b0, i_Rst_Vec, 3'b000}
- o_IME_Set  out  1  RETI interrupt-enable pulse

Behaviour:
- Reset (async, any time, including mid-op): state IDLE, counters 0, all outputs 0. o_Vector is 0 until the first RST latches.
- States: IDLE -> RUN on i_Start. RUN -> IDLE after the last step of the last M-cycle.
- i_Start while busy is ignored.
- i_Op, i_P, i_Rst_Vec are latched at start. Outputs are decoded from latched values plus counters; all outputs are registered-free combinational decode of state.
- Step counter runs 0..STEPS_PER_MCYCLE-1 and wraps.
  - At step STEPS-1 with i_Wait=1, the step and M-cycle counters hold.
  - Outputs for that step stay asserted while held.
- Within each M-cycle:
  - Memory access: step 0 asserts o_Address_Out, o_Read16[SP_INDEX], plus data enables.
  - SP adjust: step 1 asserts o_Write16[SP_INDEX] and o_Increment16.
- M-cycle sequences (M0 = first M-cycle after the opcode fetch):
  - POP: M0 read [SP]->lo, SP++. M1 read [SP]->hi, SP++. 2 M-cycles.
  - PUSH: M0 SP--. M1 write hi->[SP], SP--. M2 write lo->[SP]. 3 M-cycles.
  - RET / RETI: M0 read lo->PC_lo, SP++. M1 read hi->PC_hi, SP++. M2 internal PC commit (o_Write16[PC_INDEX] at step 0). 3 M-cycles. RETI pulses o_IME_Set with o_Done.
  - RET cc: M0 internal; i_Cond sampled at step 0. False: done after M0. True: the RET sequence follows (4 total).
  - RST: as PUSH with PC bytes as data source. The final M-cycle also asserts o_Load_Vector at step 1. 3 M-cycles.
- AF pair: when the selected pair is the top index, all data enables go to o_WriteALU8/o_ReadALU8; o_Write8/o_Read8 stay 0.
- Bus direction: o_Bus_In and o_Bus_Out are mutually exclusive, never both 1.
- o_IR_Fetch is high throughout the final M-cycle.
- o_Done pulses at the final step of the final M-cycle. o_Busy drops the following cycle.
- A new i_Start in the same cycle as o_Done is ignored.

Decomposition:
- Shared package:
  - op enum: POP=0, PUSH=1, RET=2, RETI=3, RETCC=4, RST=5
  - M-cycle count per op
  - SP_INDEX/PC_INDEX constants
  - increment direction encoding
- One sub-module, stack_step_counter: T-step/M-cycle counter with wait-hold and terminal flags.

Test Plan:
- Reset, then POP with i_P=4'b0001 -> 8 clocks busy. o_Write8[0] in M0 step 0 and o_Write8[1] in M1 step 0. o_Increment16=2'b01 twice. o_IR_Fetch only in M1. o_Done at clock 8.
- PUSH with i_P=4'b1000 -> o_Increment16=2'b10 in M0 and M1. o_ReadALU8 A then F with o_Bus_Out. o_Write8 and o_Read8 all 0. 12 clocks.
- RET cc with i_Cond=0 -> done after 4 clocks with no bus activity. Repeat with i_Cond=1 -> 16 clocks and PC write-back in M3.
- RST with i_Rst_Vec=3'd7 -> o_Vector=16'h0038 and o_Load_Vector in M2 step 1. PC hi written before PC lo.
- POP with i_Wait=1 for 3 clocks at M0 step 3 -> outputs held. Total 11 clocks.
- i_Reset_n low at PUSH M1 step 1 -> all outputs 0 immediately. i_Start after release -> clean start from M0.
